// File: rtl/dit_fetch.sv
// dit_fetch: clocked reader for the bit-reversed sample store.
// Walks slots 0..FFT_VLEN-1 in natural order through the store's
// choose/get read interface and hands each sample to the first butterfly
// stage on a valid/ready stream carrying index and last-flag sideband.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            request one frame fetch (sampled only in IDLE)
//   store_choose     slot select to the store (MSB tied 0)
//   store_get        one-cycle read strobe; store latches on its rising edge
//   store_data       store read output
//   out_data/out_index/out_last/out_valid, out_ready   sample stream
//   busy             high whenever not IDLE
//   done             one-cycle pulse after the last handshake of a frame
module dit_fetch #(
  parameter int ADC_DATLEN    = 12,
  parameter int FFT_VLEN      = 16,
  parameter int FFT_VLEN_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [FFT_VLEN_LOG2:0]   store_choose,
  output logic                     store_get,
  input  logic [ADC_DATLEN-1:0]    store_data,
  output logic [ADC_DATLEN-1:0]    out_data,
  output logic [FFT_VLEN_LOG2-1:0] out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_CAPTURE, S_PRESENT, S_DONE
  } state_t;

  localparam logic [FFT_VLEN_LOG2-1:0] LAST_IDX = FFT_VLEN_LOG2'(FFT_VLEN - 1);

  state_t                   state_q, state_d;
  logic [FFT_VLEN_LOG2-1:0] cnt_q, cnt_d;
  logic [FFT_VLEN_LOG2:0]   choose_q, choose_d;
  logic                     get_q, get_d;
  logic [ADC_DATLEN-1:0]    data_q, data_d;
  logic [FFT_VLEN_LOG2-1:0] index_q, index_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    get_d   = 1'b0;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // strobe goes high in the following cycle, after choose has
        // already been stable for a full cycle
        get_d   = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = store_data;
        index_d = cnt_q;
        last_d  = (cnt_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SETUP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // choose mirrors the counter, so it only moves on entry to SETUP and
    // stays put across SETUP, STROBE and CAPTURE
    choose_d = {1'b0, cnt_d};
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      choose_q <= '0;
      get_q    <= 1'b0;
      data_q   <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      choose_q <= choose_d;
      get_q    <= get_d;
      data_q   <= data_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign store_choose = choose_q;
  assign store_get    = get_q;
  assign out_data     = data_q;
  assign out_index    = index_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dit_fetch.sv
module tb_dit_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  store_choose;
  logic        store_get;
  logic [11:0] store_data = '0;
  logic [11:0] out_data;
  logic [3:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;

  dit_fetch #(.ADC_DATLEN(12), .FFT_VLEN(16), .FFT_VLEN_LOG2(4)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .store_choose(store_choose), .store_get(store_get), .store_data(store_data),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // store model: latches selected slot on the strobe rising edge
  logic [11:0] mem [16];
  always @(posedge store_get) store_data <= mem[store_choose[3:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // observation queues filled by the monitor
  logic [11:0] qd[$];
  logic [3:0]  qi[$];
  logic        ql[$];
  logic [4:0]  qc[$];
  int          qdone[$];

  logic        p_valid = 0, p_ready = 0, p_done = 0, p_last = 0;
  logic [11:0] p_data = 0;
  logic [3:0]  p_index = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_valid = 0; p_ready = 0; p_done = 0;
    end else begin
      if (out_valid && out_ready) begin
        qd.push_back(out_data); qi.push_back(out_index); ql.push_back(out_last);
      end
      if (store_get) begin
        qc.push_back(store_choose);
        chk("choose_msb", store_choose[4], 1'b0);
      end
      if (done) qdone.push_back(cyc);
      if (p_done) chk("busy_after_done", busy, 1'b0);
      // sample must be held while the consumer stalls
      if (p_valid && !p_ready) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, p_data);
        chk("stall_index", out_index, p_index);
        chk("stall_last", out_last, p_last);
      end
      p_valid = out_valid; p_ready = out_ready; p_done = done;
      p_data = out_data; p_index = out_index; p_last = out_last;
    end
  end

  // consumer: optionally stalls 5 cycles each time a sample appears
  logic stall_en = 1'b0;
  int   vcnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (out_valid) vcnt++; else vcnt = 0;
    out_ready = !stall_en || (vcnt > 5);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    qd.delete(); qi.delete(); ql.delete(); qc.delete(); qdone.delete();
  endtask

  // returns the cycle count value seen during the first SETUP cycle
  task automatic pulse_start(output int e0);
    start = 1'b1;
    step();
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (qdone.size() >= n) break;
      step();
    end
    chk("frame_timeout", qdone.size() >= n, 1'b1);
    step(); step();
  endtask

  task automatic check_frame(input int f);
    for (int k = 0; k < 16; k++) begin
      int j = f * 16 + k;
      if (j < qd.size()) begin
        chk("data", qd[j], mem[k]);
        chk("index", qi[j], k);
        chk("last", ql[j], k == 15);
      end else chk("sample_missing", j, qd.size());
      if (j < qc.size()) chk("choose", qc[j], k);
      else chk("strobe_missing", j, qc.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_choose"}, store_choose, 0);
    chk({tag, "_get"}, store_get, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int e0;
  int ok;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 12'h100 + 12'(k);
    #3;
    chk_reset_outputs("reset");
    step(); step();
    rst = 1'b0;
    step();

    // 1: no backpressure; done lands in cycle 65 counting SETUP as cycle 1
    clr();
    pulse_start(e0);
    wait_done(1, 200);
    check_frame(0);
    chk("t1_strobes", qc.size(), 16);
    chk("t1_samples", qd.size(), 16);
    if (qdone.size() > 0) chk("t1_done_cycle", qdone[0] - e0 + 1, 65);
    chk("t1_done_count", qdone.size(), 1);

    // 2: 5 stall cycles per sample -> 65 + 16*5
    stall_en = 1'b1;
    clr();
    pulse_start(e0);
    wait_done(1, 400);
    check_frame(0);
    if (qdone.size() > 0) chk("t2_done_cycle", qdone[0] - e0 + 1, 145);
    stall_en = 1'b0;
    step();

    // 3: start re-pulsed at index 7 and during DONE is ignored
    clr();
    pulse_start(e0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid && out_index == 4'd7) ok = 1; else step();
    end
    chk("t3_reach_idx7", ok, 1);
    start = 1'b1; step(); start = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (done) ok = 1; else step();
    end
    chk("t3_reach_done", ok, 1);
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    chk("t3_samples", qd.size(), 16);
    chk("t3_done_count", qdone.size(), 1);
    chk("t3_idle_busy", busy, 0);
    clr();
    pulse_start(e0);
    wait_done(1, 200);
    check_frame(0);

    // 4: start held high -> three frames; a done-to-done distance of 66
    // edges is 64 busy cycles + DONE + exactly one IDLE cycle
    clr();
    start = 1'b1;
    step();
    e0 = cyc;
    for (int i = 0; i < 400; i++) begin
      if (qdone.size() >= 3) break;
      step();
    end
    start = 1'b0;
    repeat (4) step();
    chk("t4_done_count", qdone.size(), 3);
    chk("t4_samples", qd.size(), 48);
    if (qdone.size() >= 3) begin
      chk("t4_done0_cycle", qdone[0] - e0 + 1, 65);
      chk("t4_spacing01", qdone[1] - qdone[0], 66);
      chk("t4_spacing12", qdone[2] - qdone[1], 66);
    end
    for (int f = 0; f < 3; f++) check_frame(f);

    // 5: async reset mid-cycle during STROBE of slot 9
    clr();
    pulse_start(e0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (store_get && store_choose == 5'd9) ok = 1; else step();
    end
    chk("t5_reach_strobe9", ok, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("t5_async");
    step(); step();
    rst = 1'b0;
    step();
    clr();
    pulse_start(e0);
    wait_done(1, 200);
    check_frame(0);

    // 6: full-width extremes pass unaltered, last only with 12'hFFF
    mem[0] = 12'h000;
    mem[15] = 12'hFFF;
    clr();
    pulse_start(e0);
    wait_done(1, 200);
    check_frame(0);
    if (qd.size() >= 16) begin
      chk("t6_first", qd[0], 12'h000);
      chk("t6_last_data", qd[15], 12'hFFF);
    end
    ok = 0;
    for (int j = 0; j < ql.size(); j++) if (ql[j]) ok++;
    chk("t6_last_count", ok, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
